// File: rtl/issue_pkg.sv
// Shared types and widths for the out-of-order issue queue.
//   CFG_ILEN / CFG_RS_DEPTH : global configuration defaults (operand width, station depth)
//   DATA_W / TAG_W          : operand and ROB/physical tag widths
//   uop_t                   : decoded integer micro-op carried through the station
//   rs_entry_t              : one reservation-station slot
//   wake_t                  : result of a CDB tag lookup
package issue_pkg;

  localparam int unsigned CFG_ILEN     = 32;
  localparam int unsigned CFG_RS_DEPTH = 16;

  localparam int unsigned DATA_W = CFG_ILEN;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned IDX_W  = $clog2(CFG_RS_DEPTH);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu, OpLui, OpNop
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [3:0] aux;
  } uop_t;

  typedef struct packed {
    logic              busy;
    uop_t              uop;
    logic [TAG_W-1:0]  dst;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q1;
    logic              r1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  q2;
    logic              r2;
  } rs_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] val;
  } wake_t;

endpackage

// File: rtl/iq_age_select.sv
// Age tracking and oldest-first multi-port select for the issue queue.
//   clk, rst, flush : clock, synchronous active-high reset, kill-all
//   busy, ready     : per-entry occupancy and operand-ready state
//   alloc_oh        : per dispatch lane, one-hot entry allocated this cycle (lane 0 oldest)
//   iss_ready       : per issue port, FU accepts this cycle
//   grant/grant_idx : per issue port, one-hot and binary index of the selected entry
//   free            : entries whose issue handshake completes this cycle
module iq_age_select #(
  parameter int unsigned RS_DEPTH   = 16,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic [RS_DEPTH-1:0]                          busy,
  input  logic [RS_DEPTH-1:0]                          ready,
  input  logic [DISPATCH_W-1:0][RS_DEPTH-1:0]          alloc_oh,
  input  logic [ISSUE_W-1:0]                           iss_ready,
  output logic [ISSUE_W-1:0][RS_DEPTH-1:0]             grant,
  output logic [ISSUE_W-1:0][$clog2(RS_DEPTH)-1:0]     grant_idx,
  output logic [RS_DEPTH-1:0]                          free
);

  localparam int unsigned EIDX_W = $clog2(RS_DEPTH);

  // older_q[i][j] = 1 means entry j was allocated before entry i.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

  // Each port takes the entry with no older candidate left, then removes it from the pool.
  always_comb begin
    logic [RS_DEPTH-1:0] cand;
    cand      = ready;
    grant     = '0;
    grant_idx = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (cand[i] && ((older_q[i] & cand) == '0)) begin
          grant[p][i]  = 1'b1;
          grant_idx[p] = EIDX_W'(i);
        end
      end
      cand = cand & ~grant[p];
    end
  end

  always_comb begin
    free = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (iss_ready[p]) free = free | grant[p];
    end
  end

  always_comb begin
    logic [RS_DEPTH-1:0] prior;
    older_d = older_q;
    for (int j = 0; j < RS_DEPTH; j++) begin
      if (free[j]) begin
        for (int i = 0; i < RS_DEPTH; i++) older_d[i][j] = 1'b0;
      end
    end
    // New entry is younger than every survivor and than earlier lanes of this cycle.
    prior = busy & ~free;
    for (int l = 0; l < DISPATCH_W; l++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc_oh[l][i]) older_d[i] = prior;
      end
      prior = prior | alloc_oh[l];
    end
    if (flush) older_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) older_q <= '0;
    else     older_q <= older_d;
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: reservation station between rename/dispatch and the integer FUs.
//   clk, rst, flush      : clock, synchronous active-high reset, kill all entries
//   disp_*               : DISPATCH_W dispatch lanes (uop, dest tag, operands/tags/ready bits)
//   disp_ready           : at least DISPATCH_W free entries; dispatch only accepted when high
//   cdb_valid/tag/val    : CDB_W result broadcast buses for operand wakeup
//   iss_valid/iss_ready  : ISSUE_W FU ports with valid/ready handshake
//   iss_uop/dst/v1/v2    : issued uop, dest tag and operands (combinational from selected entry)
//   free_count           : registered number of non-busy entries
module issue_queue
  import issue_pkg::*;
#(
  parameter int unsigned RS_DEPTH   = CFG_RS_DEPTH,
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned CDB_W      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [DISPATCH_W-1:0]                 disp_valid,
  input  uop_t [DISPATCH_W-1:0]                 disp_uop,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_dst,
  input  logic [DISPATCH_W-1:0][DATA_W-1:0]     disp_v1,
  input  logic [DISPATCH_W-1:0][DATA_W-1:0]     disp_v2,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_q1,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_q2,
  input  logic [DISPATCH_W-1:0]                 disp_r1,
  input  logic [DISPATCH_W-1:0]                 disp_r2,
  output logic                                  disp_ready,
  input  logic [CDB_W-1:0]                      cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]           cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]          cdb_val,
  output logic [ISSUE_W-1:0]                    iss_valid,
  input  logic [ISSUE_W-1:0]                    iss_ready,
  output uop_t [ISSUE_W-1:0]                    iss_uop,
  output logic [ISSUE_W-1:0][TAG_W-1:0]         iss_dst,
  output logic [ISSUE_W-1:0][DATA_W-1:0]        iss_v1,
  output logic [ISSUE_W-1:0][DATA_W-1:0]        iss_v2,
  output logic [$clog2(RS_DEPTH):0]             free_count
);

  localparam int unsigned CNT_W  = $clog2(RS_DEPTH) + 1;
  localparam int unsigned EIDX_W = $clog2(RS_DEPTH);

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  logic [CNT_W-1:0] free_count_q, free_count_d;

  logic [RS_DEPTH-1:0]                 busy, ready_vec, free_vec;
  logic [DISPATCH_W-1:0][RS_DEPTH-1:0] alloc_oh;
  logic [ISSUE_W-1:0][RS_DEPTH-1:0]    grant;
  logic [ISSUE_W-1:0][EIDX_W-1:0]      grant_idx;
  logic                                dispatch_en;

  // Lowest CDB index wins when several buses carry the same tag.
  function automatic wake_t cdb_lookup(input logic [TAG_W-1:0]             tag,
                                       input logic [CDB_W-1:0]             vld,
                                       input logic [CDB_W-1:0][TAG_W-1:0]  tags,
                                       input logic [CDB_W-1:0][DATA_W-1:0] vals);
    wake_t w;
    w = '0;
    for (int k = int'(CDB_W) - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k] == tag)) begin
        w.hit = 1'b1;
        w.val = vals[k];
      end
    end
    return w;
  endfunction

  assign disp_ready  = (free_count_q >= CNT_W'(DISPATCH_W));
  assign dispatch_en = disp_ready & ~flush;
  assign free_count  = free_count_q;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy[i]      = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].r1 & ent_q[i].r2;
    end
  end

  // Valid lanes take the lowest entries that were free at the start of the cycle.
  always_comb begin
    logic [RS_DEPTH-1:0] taken;
    logic                found;
    taken    = busy;
    alloc_oh = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      found = 1'b0;
      if (dispatch_en && disp_valid[l]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!found && !taken[i]) begin
            alloc_oh[l][i] = 1'b1;
            found          = 1'b1;
          end
        end
      end
      taken = taken | alloc_oh[l];
    end
  end

  iq_age_select #(
    .RS_DEPTH   (RS_DEPTH),
    .DISPATCH_W (DISPATCH_W),
    .ISSUE_W    (ISSUE_W)
  ) u_age_select (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .busy      (busy),
    .ready     (ready_vec),
    .alloc_oh  (alloc_oh),
    .iss_ready (iss_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .free      (free_vec)
  );

  always_comb begin
    wake_t w1, w2;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      w1 = cdb_lookup(ent_q[i].q1, cdb_valid, cdb_tag, cdb_val);
      w2 = cdb_lookup(ent_q[i].q2, cdb_valid, cdb_tag, cdb_val);
      if (ent_q[i].busy && !ent_q[i].r1 && w1.hit) begin
        ent_d[i].r1 = 1'b1;
        ent_d[i].v1 = w1.val;
      end
      if (ent_q[i].busy && !ent_q[i].r2 && w2.hit) begin
        ent_d[i].r2 = 1'b1;
        ent_d[i].v2 = w2.val;
      end
      if (free_vec[i]) ent_d[i].busy = 1'b0;
    end
    for (int l = 0; l < DISPATCH_W; l++) begin
      w1 = cdb_lookup(disp_q1[l], cdb_valid, cdb_tag, cdb_val);
      w2 = cdb_lookup(disp_q2[l], cdb_valid, cdb_tag, cdb_val);
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc_oh[l][i]) begin
          ent_d[i].busy = 1'b1;
          ent_d[i].uop  = disp_uop[l];
          ent_d[i].dst  = disp_dst[l];
          ent_d[i].q1   = disp_q1[l];
          ent_d[i].q2   = disp_q2[l];
          ent_d[i].r1   = disp_r1[l] | w1.hit;
          ent_d[i].r2   = disp_r2[l] | w2.hit;
          ent_d[i].v1   = disp_r1[l] ? disp_v1[l] : w1.val;
          ent_d[i].v2   = disp_r2[l] ? disp_v2[l] : w2.val;
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!ent_d[i].busy) free_count_d = free_count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      free_count_q <= CNT_W'(RS_DEPTH);
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      free_count_q <= free_count_d;
    end
  end

  always_comb begin
    for (int p = 0; p < ISSUE_W; p++) begin
      iss_valid[p] = |grant[p];
      iss_uop[p]   = ent_q[grant_idx[p]].uop;
      iss_dst[p]   = ent_q[grant_idx[p]].dst;
      iss_v1[p]    = ent_q[grant_idx[p]].v1;
      iss_v2[p]    = ent_q[grant_idx[p]].v2;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (RS_DEPTH=16, 4 dispatch, 2 issue, 4 CDB).
module tb_issue_queue;
  import issue_pkg::*;

  localparam int unsigned RS_DEPTH = 16;
  localparam int unsigned DW       = 4;
  localparam int unsigned IW       = 2;
  localparam int unsigned CW       = 4;

  logic clk = 1'b0;
  logic rst, flush;
  logic [DW-1:0]              disp_valid;
  uop_t [DW-1:0]              disp_uop;
  logic [DW-1:0][TAG_W-1:0]   disp_dst, disp_q1, disp_q2;
  logic [DW-1:0][DATA_W-1:0]  disp_v1, disp_v2;
  logic [DW-1:0]              disp_r1, disp_r2;
  logic                       disp_ready;
  logic [CW-1:0]              cdb_valid;
  logic [CW-1:0][TAG_W-1:0]   cdb_tag;
  logic [CW-1:0][DATA_W-1:0]  cdb_val;
  logic [IW-1:0]              iss_valid, iss_ready;
  uop_t [IW-1:0]              iss_uop;
  logic [IW-1:0][TAG_W-1:0]   iss_dst;
  logic [IW-1:0][DATA_W-1:0]  iss_v1, iss_v2;
  logic [$clog2(RS_DEPTH):0]  free_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_queue #(
    .RS_DEPTH   (RS_DEPTH),
    .DISPATCH_W (DW),
    .ISSUE_W    (IW),
    .CDB_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_uop   (disp_uop),
    .disp_dst   (disp_dst),
    .disp_v1    (disp_v1),
    .disp_v2    (disp_v2),
    .disp_q1    (disp_q1),
    .disp_q2    (disp_q2),
    .disp_r1    (disp_r1),
    .disp_r2    (disp_r2),
    .disp_ready (disp_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_uop    (iss_uop),
    .iss_dst    (iss_dst),
    .iss_v1     (iss_v1),
    .iss_v2     (iss_v2),
    .free_count (free_count)
  );

  function automatic uop_t mk_uop(input logic [TAG_W-1:0] dst);
    uop_t u;
    u.op  = alu_op_e'({2'b00, dst[1:0]});
    u.aux = dst[3:0];
    return u;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    disp_valid = '0;
    cdb_valid  = '0;
  endtask

  task automatic lane(input int l, input logic [TAG_W-1:0] dst,
                      input logic r1, input logic [TAG_W-1:0] q1, input logic [DATA_W-1:0] v1,
                      input logic r2, input logic [TAG_W-1:0] q2, input logic [DATA_W-1:0] v2);
    disp_valid[l] = 1'b1;
    disp_uop[l]   = mk_uop(dst);
    disp_dst[l]   = dst;
    disp_r1[l]    = r1;
    disp_q1[l]    = q1;
    disp_v1[l]    = v1;
    disp_r2[l]    = r2;
    disp_q2[l]    = q2;
    disp_v2[l]    = v2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    iss_ready = '0;
    disp_uop = '0; disp_dst = '0; disp_q1 = '0; disp_q2 = '0;
    disp_v1 = '0; disp_v2 = '0; disp_r1 = '0; disp_r2 = '0;
    cdb_tag = '0; cdb_val = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_free_count", free_count, 16);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);

    // 1: four ready uops in one cycle, both ports accepting
    iss_ready = 2'b11;
    for (int l = 0; l < 4; l++) lane(l, TAG_W'(l + 1), 1'b1, '0, 32'h101 + l, 1'b1, '0, 32'h201 + l);
    tick();
    idle();
    chk("t1_fc_after_disp", free_count, 12);
    chk("t1_valid_a", iss_valid, 2'b11);
    chk("t1_dst0_a", iss_dst[0], 1);
    chk("t1_dst1_a", iss_dst[1], 2);
    chk("t1_v1_p0", iss_v1[0], 32'h101);
    chk("t1_v2_p1", iss_v2[1], 32'h202);
    chk("t1_uop_p1", iss_uop[1], {OpAnd, 4'd2});
    tick();
    chk("t1_fc_mid", free_count, 14);
    chk("t1_dst0_b", iss_dst[0], 3);
    chk("t1_dst1_b", iss_dst[1], 4);
    tick();
    chk("t1_fc_end", free_count, 16);
    chk("t1_valid_end", iss_valid, 0);

    // 2: fill the station with entries waiting on tag 9
    for (int c = 0; c < 4; c++) begin
      chk("t2_disp_ready_fill", disp_ready, 1);
      for (int l = 0; l < 4; l++) lane(l, TAG_W'(10 + 4 * c + l), 1'b0, 6'd9, '0, 1'b1, '0, 32'h300);
      tick();
      idle();
    end
    chk("t2_fc_full", free_count, 0);
    chk("t2_disp_ready_full", disp_ready, 0);
    chk("t2_valid_full", iss_valid, 0);
    for (int l = 0; l < 4; l++) lane(l, TAG_W'(40 + l), 1'b1, '0, '0, 1'b1, '0, '0);
    tick();
    idle();
    chk("t2_fc_drop", free_count, 0);
    cdb_valid  = 4'b0001;
    cdb_tag[0] = 6'd9;
    cdb_val[0] = 32'hAB;
    tick();
    idle();
    chk("t2_v1_p0", iss_v1[0], 32'hAB);
    chk("t2_v1_p1", iss_v1[1], 32'hAB);
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_dst0", iss_dst[0], 10 + 2 * k);
      chk("t2_drain_dst1", iss_dst[1], 11 + 2 * k);
      tick();
    end
    chk("t2_fc_end", free_count, 16);
    chk("t2_valid_end", iss_valid, 0);

    // 3: dispatch-cycle wakeup, lowest valid CDB index wins
    lane(0, 6'd30, 1'b1, '0, 32'h11, 1'b0, 6'd7, '0);
    cdb_valid = 4'b1101;
    cdb_tag[0] = 6'd8; cdb_val[0] = 32'h99;
    cdb_tag[1] = 6'd7; cdb_val[1] = 32'h77;
    cdb_tag[2] = 6'd7; cdb_val[2] = 32'h55;
    cdb_tag[3] = 6'd7; cdb_val[3] = 32'h66;
    tick();
    idle();
    chk("t3_valid", iss_valid, 2'b01);
    chk("t3_dst", iss_dst[0], 30);
    chk("t3_v1", iss_v1[0], 32'h11);
    chk("t3_v2", iss_v2[0], 32'h55);
    tick();
    chk("t3_fc_end", free_count, 16);

    // 4: port 0 stalled, port 1 accepting; oldest stays held on port 0
    iss_ready = 2'b10;
    lane(0, 6'd41, 1'b1, '0, '0, 1'b1, '0, '0);
    lane(1, 6'd42, 1'b1, '0, '0, 1'b1, '0, '0);
    lane(2, 6'd43, 1'b1, '0, '0, 1'b1, '0, '0);
    tick();
    idle();
    chk("t4_valid_a", iss_valid, 2'b11);
    chk("t4_dst0_a", iss_dst[0], 41);
    chk("t4_dst1_a", iss_dst[1], 42);
    tick();
    chk("t4_dst0_b", iss_dst[0], 41);
    chk("t4_dst1_b", iss_dst[1], 43);
    tick();
    chk("t4_valid_c", iss_valid, 2'b01);
    chk("t4_dst0_c", iss_dst[0], 41);
    chk("t4_fc_c", free_count, 15);
    iss_ready = 2'b11;
    tick();
    chk("t4_fc_end", free_count, 16);
    chk("t4_valid_end", iss_valid, 0);

    // 5: flush beats a same-cycle dispatch
    for (int l = 0; l < 3; l++) lane(l, TAG_W'(50 + l), 1'b0, 6'd33, '0, 1'b1, '0, '0);
    tick();
    idle();
    chk("t5_fc_busy", free_count, 13);
    chk("t5_valid_busy", iss_valid, 0);
    flush = 1'b1;
    lane(0, 6'd60, 1'b1, '0, '0, 1'b1, '0, '0);
    lane(2, 6'd62, 1'b1, '0, '0, 1'b1, '0, '0);
    tick();
    idle();
    chk("t5_fc_flush", free_count, 16);
    chk("t5_valid_flush", iss_valid, 0);
    chk("t5_ready_flush", disp_ready, 1);
    cdb_valid  = 4'b0001;
    cdb_tag[0] = 6'd33;
    tick();
    idle();
    chk("t5_valid_post", iss_valid, 0);
    chk("t5_fc_post", free_count, 16);

    // 6: sparse lanes, lane 1 older than lane 3
    iss_ready = 2'b00;
    lane(1, 6'd21, 1'b1, '0, '0, 1'b1, '0, '0);
    lane(3, 6'd23, 1'b1, '0, '0, 1'b1, '0, '0);
    tick();
    idle();
    chk("t6_fc", free_count, 14);
    chk("t6_valid", iss_valid, 2'b11);
    chk("t6_dst0", iss_dst[0], 21);
    chk("t6_dst1", iss_dst[1], 23);
    iss_ready = 2'b11;
    tick();
    chk("t6_fc_end", free_count, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
